ip_codma_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing the codma memory bus between NUM_REQ requesters: read machine, write machine, status writer.

---
 rtl/ip_codma_bus_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_ip_codma_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_bus_arbiter.sv
// ip_codma_bus_arbiter
// Round-robin arbiter for the codma memory bus. It is the only driver of the bus
// read/write/addr/size lines. An owner keeps the bus from its request until it pulses
// its done line, and priority then rotates to the next index.
//
// Optional feature: define CODMA_ARB_TIMEOUT_EN to build in the watchdog. The watchdog
// moves the FSM to ARB_ERROR when a transaction spends TIMEOUT_CYCLES cycles in ASK+OWNED.
// Without the macro, timeout_err_o is tied low.
//
// Ports
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   stop_i             abort: drop ownership and return to idle
//   req_i              per-requester level request
//   req_write_i        per-requester direction (1 = write)
//   req_addr_i         packed 32-bit addresses, requester 0 in the LSBs
//   req_size_i         packed SIZE_W-bit sizes
//   req_done_i         owner's one-cycle completion pulse
//   gnt_o              one-hot ownership grant
//   owner_o            index of the current or last owner
//   busy_o             high in every state except ARB_IDLE
//   bus_read_o/_write_o/_addr_o/_size_o   bus request to the memory bus
//   bus_grant_i        bus accepts the pending request
//   timeout_err_o      sticky watchdog error
//
// state       | meaning
// ARB_IDLE    | no owner; scan requests from rr_ptr
// ARB_ASK     | owner selected, bus request driven, waiting for bus_grant_i
// ARB_OWNED   | grant given to owner, waiting for its req_done_i
// ARB_RELEASE | one cycle to drop the grant and advance rr_ptr
// ARB_ERROR   | watchdog expired; held until stop_i (watchdog build only)
module ip_codma_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int SIZE_W         = 8,
    parameter int IDLE_SIZE      = 9,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       stop_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         req_write_i,
    input  logic [NUM_REQ*32-1:0]      req_addr_i,
    input  logic [NUM_REQ*SIZE_W-1:0]  req_size_i,
    input  logic [NUM_REQ-1:0]         req_done_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic                       bus_read_o,
    output logic                       bus_write_o,
    output logic [31:0]                bus_addr_o,
    output logic [SIZE_W-1:0]          bus_size_o,
    input  logic                       bus_grant_i,
    output logic                       timeout_err_o
);

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam logic [SIZE_W-1:0] SIZE_IDLE = SIZE_W'(IDLE_SIZE);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_cfg_chk
        $error("ip_codma_bus_arbiter: NUM_REQ and TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_ASK     = 3'd1,
        ARB_OWNED   = 3'd2,
        ARB_RELEASE = 3'd3,
        ARB_ERROR   = 3'd4
    } arb_state_t;

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_idx;

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;
    logic             w_any_req;
    logic [IDX_W-1:0] w_sel_idx;
    logic [NUM_REQ-1:0] w_idx_onehot;

    // Walk candidates from farthest to nearest so the one closest to rr_ptr is kept.
    always_comb begin
        w_any_req  = 1'b0;
        w_sel_idx  = r_rr_ptr;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = int'(r_rr_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = IDX_W'(w_cand);
            if (req_i[w_cand_idx]) begin
                w_any_req = 1'b1;
                w_sel_idx = w_cand_idx;
            end
        end
    end

    assign w_idx_onehot = NUM_REQ'(1) << r_idx;

`ifdef CODMA_ARB_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_tmr;
    logic             w_tmr_expire;

    // Down-counter loaded outside ASK/OWNED; reaching zero in the last allowed cycle trips it.
    assign w_tmr_expire = ((r_state == ARB_ASK) || (r_state == ARB_OWNED)) && (r_tmr == '0);
`else
    assign timeout_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            gnt_o       <= '0;
            owner_o     <= '0;
            busy_o      <= 1'b0;
            bus_read_o  <= 1'b0;
            bus_write_o <= 1'b0;
            bus_addr_o  <= '0;
            bus_size_o  <= SIZE_IDLE;
`ifdef CODMA_ARB_TIMEOUT_EN
            r_tmr         <= TMR_LOAD;
            timeout_err_o <= 1'b0;
`endif
        end else if (stop_i) begin
            r_state     <= ARB_IDLE;
            gnt_o       <= '0;
            busy_o      <= 1'b0;
            bus_read_o  <= 1'b0;
            bus_write_o <= 1'b0;
            bus_addr_o  <= '0;
            bus_size_o  <= SIZE_IDLE;
`ifdef CODMA_ARB_TIMEOUT_EN
            r_tmr         <= TMR_LOAD;
            timeout_err_o <= 1'b0;
        end else if (w_tmr_expire) begin
            r_state       <= ARB_ERROR;
            gnt_o         <= '0;
            busy_o        <= 1'b1;
            bus_read_o    <= 1'b0;
            bus_write_o   <= 1'b0;
            bus_addr_o    <= '0;
            bus_size_o    <= SIZE_IDLE;
            timeout_err_o <= 1'b1;
`endif
        end else begin
`ifdef CODMA_ARB_TIMEOUT_EN
            if ((r_state == ARB_ASK) || (r_state == ARB_OWNED)) begin
                r_tmr <= r_tmr - 1'b1;
            end else begin
                r_tmr <= TMR_LOAD;
            end
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ARB_ASK;
                        r_idx       <= w_sel_idx;
                        owner_o     <= w_sel_idx;
                        busy_o      <= 1'b1;
                        bus_read_o  <= !req_write_i[w_sel_idx];
                        bus_write_o <= req_write_i[w_sel_idx];
                        bus_addr_o  <= req_addr_i[32*int'(w_sel_idx) +: 32];
                        bus_size_o  <= req_size_i[SIZE_W*int'(w_sel_idx) +: SIZE_W];
                    end else begin
                        busy_o      <= 1'b0;
                        bus_read_o  <= 1'b0;
                        bus_write_o <= 1'b0;
                        bus_addr_o  <= '0;
                        bus_size_o  <= SIZE_IDLE;
                    end
                end
                ARB_ASK: begin
                    // Grant takes precedence over a same-cycle withdraw.
                    if (bus_grant_i) begin
                        r_state     <= ARB_OWNED;
                        gnt_o       <= w_idx_onehot;
                        bus_read_o  <= 1'b0;
                        bus_write_o <= 1'b0;
                    end else if (!req_i[r_idx]) begin
                        r_state     <= ARB_IDLE;
                        busy_o      <= 1'b0;
                        bus_read_o  <= 1'b0;
                        bus_write_o <= 1'b0;
                        bus_addr_o  <= '0;
                        bus_size_o  <= SIZE_IDLE;
                    end
                end
                ARB_OWNED: begin
                    if (req_done_i[r_idx]) begin
                        r_state    <= ARB_RELEASE;
                        gnt_o      <= '0;
                        bus_addr_o <= '0;
                        bus_size_o <= SIZE_IDLE;
                    end
                end
                ARB_RELEASE: begin
                    r_state  <= ARB_IDLE;
                    busy_o   <= 1'b0;
                    r_rr_ptr <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end
`ifdef CODMA_ARB_TIMEOUT_EN
                ARB_ERROR: begin
                end
                default: begin
                    r_state       <= ARB_ERROR;
                    gnt_o         <= '0;
                    busy_o        <= 1'b1;
                    bus_read_o    <= 1'b0;
                    bus_write_o   <= 1'b0;
                    bus_addr_o    <= '0;
                    bus_size_o    <= SIZE_IDLE;
                    timeout_err_o <= 1'b1;
                end
`else
                default: begin
                    r_state     <= ARB_IDLE;
                    gnt_o       <= '0;
                    busy_o      <= 1'b0;
                    bus_read_o  <= 1'b0;
                    bus_write_o <= 1'b0;
                    bus_addr_o  <= '0;
                    bus_size_o  <= SIZE_IDLE;
                end
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
`timescale 1ns/1ps
module tb_ip_codma_bus_arbiter;

    localparam int N   = 3;
    localparam int SW  = 8;
    localparam int TMO = 16;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              stop_i;
    logic [N-1:0]      req_i;
    logic [N-1:0]      req_write_i;
    logic [N*32-1:0]   req_addr_i;
    logic [N*SW-1:0]   req_size_i;
    logic [N-1:0]      req_done_i;
    logic [N-1:0]      gnt_o;
    logic [1:0]        owner_o;
    logic              busy_o;
    logic              bus_read_o;
    logic              bus_write_o;
    logic [31:0]       bus_addr_o;
    logic [SW-1:0]     bus_size_o;
    logic              bus_grant_i;
    logic              timeout_err_o;

    ip_codma_bus_arbiter #(
        .NUM_REQ        (N),
        .SIZE_W         (SW),
        .IDLE_SIZE      (9),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .stop_i        (stop_i),
        .req_i         (req_i),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_size_i    (req_size_i),
        .req_done_i    (req_done_i),
        .gnt_o         (gnt_o),
        .owner_o       (owner_o),
        .busy_o        (busy_o),
        .bus_read_o    (bus_read_o),
        .bus_write_o   (bus_write_o),
        .bus_addr_o    (bus_addr_o),
        .bus_size_o    (bus_size_o),
        .bus_grant_i   (bus_grant_i),
        .timeout_err_o (timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who is waiting on the bus, who holds it, who is releasing.
    int          m_ptr, m_idx, m_cnt;
    bit          m_ask, m_own, m_rel, m_err;
    logic [N-1:0]  e_gnt;
    logic [1:0]    e_owner;
    logic          e_busy, e_rd, e_wr, e_terr;
    logic [31:0]   e_addr;
    logic [SW-1:0] e_size;

    task automatic model_reset();
        m_ptr = 0; m_idx = 0; m_cnt = 0;
        m_ask = 0; m_own = 0; m_rel = 0; m_err = 0;
        e_gnt = '0; e_owner = '0; e_busy = 0; e_rd = 0; e_wr = 0;
        e_addr = '0; e_size = SW'(9); e_terr = 0;
    endtask

    task automatic bus_quiet();
        e_rd = 0; e_wr = 0; e_addr = '0; e_size = SW'(9);
    endtask

    task automatic model_edge();
        if (stop_i) begin
            m_ask = 0; m_own = 0; m_rel = 0; m_err = 0;
            e_gnt = '0; e_busy = 0; e_terr = 0;
            bus_quiet();
            return;
        end
`ifdef CODMA_ARB_TIMEOUT_EN
        if (m_ask || m_own) begin
            m_cnt++;
            if (m_cnt >= TMO) begin
                m_ask = 0; m_own = 0; m_err = 1;
                e_gnt = '0; e_busy = 1; e_terr = 1;
                bus_quiet();
                return;
            end
        end
`endif
        if (m_err) return;
        if (m_rel) begin
            m_rel = 0;
            m_ptr = (m_idx + 1) % N;
            e_busy = 0;
            return;
        end
        if (m_own) begin
            if (req_done_i[m_idx]) begin
                m_own = 0; m_rel = 1; e_gnt = '0;
                bus_quiet();
            end
            return;
        end
        if (m_ask) begin
            if (bus_grant_i) begin
                m_ask = 0; m_own = 1;
                e_gnt = N'(1 << m_idx);
                e_rd = 0; e_wr = 0;
            end else if (!req_i[m_idx]) begin
                m_ask = 0; e_busy = 0;
                bus_quiet();
            end
            return;
        end
        m_cnt = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req_i[c]) begin
                m_idx = c; m_ask = 1;
                e_owner = 2'(c); e_busy = 1;
                e_rd = !req_write_i[c]; e_wr = req_write_i[c];
                e_addr = req_addr_i[c*32 +: 32];
                e_size = req_size_i[c*SW +: SW];
                break;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".gnt"},   64'(gnt_o),         64'(e_gnt));
        chk({ph, ".owner"}, 64'(owner_o),       64'(e_owner));
        chk({ph, ".busy"},  64'(busy_o),        64'(e_busy));
        chk({ph, ".rd"},    64'(bus_read_o),    64'(e_rd));
        chk({ph, ".wr"},    64'(bus_write_o),   64'(e_wr));
        chk({ph, ".addr"},  64'(bus_addr_o),    64'(e_addr));
        chk({ph, ".size"},  64'(bus_size_o),    64'(e_size));
        chk({ph, ".terr"},  64'(timeout_err_o), 64'(e_terr));
    endtask

    task automatic step(input string ph);
        @(posedge clk_i);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic quiet_inputs();
        stop_i = 0; req_i = '0; req_done_i = '0; bus_grant_i = 0;
    endtask

    task automatic do_reset();
        reset_n_i = 0;
        #2;
        model_reset();
        check_all("rst");
        quiet_inputs();
        reset_n_i = 1;
    endtask

    // One complete transaction for requester idx: request, grant, done, drain.
    task automatic run_txn(input int idx, input string ph);
        req_i = N'(1 << idx);
        step(ph);
        bus_grant_i = 1;
        step(ph);
        bus_grant_i = 0;
        req_done_i = N'(1 << idx);
        step(ph);
        req_done_i = '0;
        req_i = '0;
        step(ph);
        step(ph);
    endtask

    int order[$];
    logic [N-1:0] prev_gnt;
    logic [N-1:0] wpat;

    initial begin
        reset_n_i = 0;
        quiet_inputs();
        req_write_i = '0;
        req_addr_i  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        req_size_i  = {8'd4, 8'd3, 8'd2};
        #12;
        model_reset();
        check_all("por");
        reset_n_i = 1;

        // Reset asserted while requester 1 is in the ask phase.
        req_i = 3'b010;
        step("rma");
        chk("rma_ask_rd", 64'(bus_read_o), 64'd1);
        reset_n_i = 0;
        #1;
        chk("rma_gnt",  64'(gnt_o),       64'd0);
        chk("rma_own",  64'(owner_o),     64'd0);
        chk("rma_busy", 64'(busy_o),      64'd0);
        chk("rma_rd",   64'(bus_read_o),  64'd0);
        chk("rma_addr", 64'(bus_addr_o),  64'd0);
        chk("rma_size", 64'(bus_size_o),  64'd9);
        model_reset();
        quiet_inputs();
        reset_n_i = 1;

        // Single read from requester 0: timing of bus request and grant.
        req_i = 3'b001;
        step("t2");
        chk("t2_rd_c2",   64'(bus_read_o), 64'd1);
        chk("t2_addr_c2", 64'(bus_addr_o), 64'h1000);
        chk("t2_size_c2", 64'(bus_size_o), 64'd2);
        step("t2");
        step("t2");
        chk("t2_rd_c4", 64'(bus_read_o), 64'd1);
        bus_grant_i = 1;
        step("t2");
        bus_grant_i = 0;
        chk("t2_gnt_c5", 64'(gnt_o),      64'b001);
        chk("t2_rd_c5",  64'(bus_read_o), 64'd0);
        repeat (3) step("t2");
        chk("t2_gnt_c8", 64'(gnt_o), 64'b001);
        req_done_i = 3'b001;
        step("t2");
        req_done_i = '0;
        req_i = '0;
        chk("t2_gnt_c9", 64'(gnt_o), 64'b000);
        step("t2");

        // All three requesting: rotation 0,1,2,0 with per-requester direction.
        do_reset();
        wpat = 3'b101;
        req_write_i = wpat;
        req_i = 3'b111;
        prev_gnt = '0;
        order.delete();
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            bus_grant_i = m_ask;
            req_done_i  = m_own ? N'(1 << m_idx) : '0;
            step("t3");
            if (m_ask) chk("t3_dir", 64'(bus_write_o), 64'(wpat[m_idx]));
            if (gnt_o != '0 && prev_gnt == '0) begin
                case (gnt_o)
                    3'b001:  order.push_back(0);
                    3'b010:  order.push_back(1);
                    3'b100:  order.push_back(2);
                    default: order.push_back(9);
                endcase
            end
            prev_gnt = gnt_o;
        end
        chk("t3_count", 64'(order.size()), 64'd4);
        if (order.size() >= 4) begin
            chk("t3_ord0", 64'(order[0]), 64'd0);
            chk("t3_ord1", 64'(order[1]), 64'd1);
            chk("t3_ord2", 64'(order[2]), 64'd2);
            chk("t3_ord3", 64'(order[3]), 64'd0);
        end
        quiet_inputs();
        req_write_i = '0;
        repeat (4) step("t3");

        // Withdraw during ask: no grant, pointer untouched.
        do_reset();
        run_txn(1, "t4");
        req_i = 3'b100;
        step("t4");
        chk("t4_own2", 64'(owner_o), 64'd2);
        req_i = 3'b000;
        step("t4");
        chk("t4_nognt", 64'(gnt_o),  64'd0);
        chk("t4_idle",  64'(busy_o), 64'd0);
        step("t4");
        req_i = 3'b111;
        step("t4");
        chk("t4_resel2", 64'(owner_o), 64'd2);
        bus_grant_i = 1;
        step("t4");
        bus_grant_i = 0;
        chk("t4_gnt2", 64'(gnt_o), 64'b100);
        req_done_i = 3'b100;
        req_i = '0;
        step("t4");
        req_done_i = '0;
        repeat (2) step("t4");

        // stop_i with done in the same owned cycle: pointer stays on 1.
        do_reset();
        run_txn(0, "t5");
        req_i = 3'b010;
        step("t5");
        bus_grant_i = 1;
        step("t5");
        bus_grant_i = 0;
        chk("t5_gnt1", 64'(gnt_o), 64'b010);
        stop_i = 1;
        req_done_i = 3'b010;
        step("t5");
        stop_i = 0;
        req_done_i = '0;
        chk("t5_stop_gnt",  64'(gnt_o),  64'd0);
        chk("t5_stop_busy", 64'(busy_o), 64'd0);
        req_i = 3'b111;
        step("t5");
        chk("t5_favour1", 64'(owner_o), 64'd1);
        quiet_inputs();
        repeat (2) step("t5");

`ifdef CODMA_ARB_TIMEOUT_EN
        // Bus never grants: watchdog after 16 cycles in ask.
        do_reset();
        req_i = 3'b001;
        step("t6");
        repeat (15) step("t6");
        chk("t6_pre_terr", 64'(timeout_err_o), 64'd0);
        chk("t6_pre_rd",   64'(bus_read_o),    64'd1);
        step("t6");
        chk("t6_terr", 64'(timeout_err_o), 64'd1);
        chk("t6_rd",   64'(bus_read_o),    64'd0);
        repeat (3) step("t6");
        chk("t6_sticky", 64'(timeout_err_o), 64'd1);
        req_i = '0;
        stop_i = 1;
        step("t6");
        stop_i = 0;
        chk("t6_clear", 64'(timeout_err_o), 64'd0);
        step("t6");
`endif

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) req_i[b] = ~req_i[b];
                if ($urandom_range(0, 7) == 0) req_write_i[b] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) req_addr_i[b*32 +: 32] = $urandom();
                if ($urandom_range(0, 7) == 0) req_size_i[b*SW +: SW] = SW'($urandom_range(0, 255));
                req_done_i[b] = ($urandom_range(0, 9) < 3);
            end
            bus_grant_i = ($urandom_range(0, 9) < 4);
            stop_i      = ($urandom_range(0, 49) == 0);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
